// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA timing generator with a delay-matched colour output pipeline.
// Counters drive the request side directly; colour, blanking and syncs leave via LATENCY stages.
module vga_timing_gen_p #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 8,
   parameter int unsigned LATENCY  = 1,
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned H_W     = $clog2(H_TOTAL),
   localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               pattern_en,
   input  logic [COLOR_W-1:0] color_data,
   output logic [H_W-1:0]     x,
   output logic [V_W-1:0]     y,
   output logic               line_start,
   output logic               frame_start,
   output logic               video_active,
   output logic [COLOR_W-1:0] rgb_out,
   output logic               h_sync,
   output logic               v_sync
);

   localparam int unsigned S_W    = COLOR_W + 3;
   localparam int unsigned P_W    = LATENCY * S_W;
   localparam int unsigned REP    = (COLOR_W + 2) / 3;
   localparam logic [S_W-1:0] STAGE_RST = {{COLOR_W{1'b0}}, 1'b0, ~HS_POL, ~VS_POL};

   logic [H_W-1:0]     h_cnt_q, h_cnt_d;
   logic [V_W-1:0]     v_cnt_q, v_cnt_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic [P_W-1:0]     pipe_q, pipe_d;

   logic [31:0]        hc, vc;
   logic               active, hs_raw, vs_raw;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] pattern, pix;
   logic [S_W-1:0]     stage_in, stage_out;

   // Counter advance; strobes are registered from the next-state counts
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (enable) begin
         if (32'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + V_W'(1);
         end else begin
            h_cnt_d = h_cnt_q + H_W'(1);
         end
      end
      line_start_d  = (h_cnt_d == '0);
      frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
   end

   // Decode of the current counter state into one pipeline input word
   always_comb begin
      hc     = 32'(h_cnt_q);
      vc     = 32'(v_cnt_q);
      active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      hs_raw = (hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC);
      vs_raw = (vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC);
      // bar = floor(hc*8/H_ACTIVE) via thresholds ceil(k*H_ACTIVE/8)
      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (hc >= (k * H_ACTIVE + 7) / 8) bar = 3'(k);
      end
      pattern = COLOR_W'({REP{bar}});
      pix     = pattern_en ? pattern : color_data;
      if (!active) pix = '0;
      stage_in = {pix, active, hs_raw ? HS_POL : ~HS_POL, vs_raw ? VS_POL : ~VS_POL};
   end

   // Shift register of LATENCY stages, newest word in the low slice
   always_comb begin
      pipe_d = pipe_q;
      if (enable) pipe_d = P_W'({pipe_q, stage_in});
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
         pipe_q        <= {LATENCY{STAGE_RST}};
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         pipe_q        <= pipe_d;
      end
   end

   assign stage_out    = pipe_q[P_W-1 -: S_W];
   assign x            = h_cnt_q;
   assign y            = v_cnt_q;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;
   assign rgb_out      = stage_out[S_W-1 -: COLOR_W];
   assign video_active = stage_out[2];
   assign h_sync       = stage_out[1];
   assign v_sync       = stage_out[0];

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Directed bench for vga_timing_gen_p: default timing, deep pipeline with inverted
// polarity, and a miniature geometry for whole-frame checks.
module tb_vga_timing_gen_p;

   logic clk;
   logic reset, enable, pattern_en;

   logic [9:0] x_a, y_a, x_b, y_b;
   logic [4:0] x_c;
   logic [3:0] y_c;
   logic       ls_a, fs_a, va_a, hs_a, vs_a;
   logic       ls_b, fs_b, va_b, hs_b, vs_b;
   logic       ls_c, fs_c, va_c, hs_c, vs_c;
   logic [7:0] rgb_a, rgb_b, rgb_c, col_a, col_b, col_c;

   int checks = 0;
   int errors = 0;

   assign col_a = x_a[7:0];
   assign col_b = x_b[7:0];
   assign col_c = 8'hA5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_gen_p u_a (
      .pixel_clk(clk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
      .color_data(col_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a),
      .video_active(va_a), .rgb_out(rgb_a), .h_sync(hs_a), .v_sync(vs_a)
   );

   vga_timing_gen_p #(.HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(3)) u_b (
      .pixel_clk(clk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
      .color_data(col_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b),
      .video_active(va_b), .rgb_out(rgb_b), .h_sync(hs_b), .v_sync(vs_b)
   );

   vga_timing_gen_p #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_c (
      .pixel_clk(clk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
      .color_data(col_c), .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c),
      .video_active(va_c), .rgb_out(rgb_c), .h_sync(hs_c), .v_sync(vs_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string w);
      chk({w, "_x_a"},  32'(x_a),   0);  chk({w, "_y_a"},  32'(y_a),   0);
      chk({w, "_ls_a"}, 32'(ls_a),  1);  chk({w, "_fs_a"}, 32'(fs_a),  1);
      chk({w, "_va_a"}, 32'(va_a),  0);  chk({w, "_rgb_a"}, 32'(rgb_a), 0);
      chk({w, "_hs_a"}, 32'(hs_a),  1);  chk({w, "_vs_a"}, 32'(vs_a),  1);
      chk({w, "_x_b"},  32'(x_b),   0);  chk({w, "_y_b"},  32'(y_b),   0);
      chk({w, "_ls_b"}, 32'(ls_b),  1);  chk({w, "_fs_b"}, 32'(fs_b),  1);
      chk({w, "_va_b"}, 32'(va_b),  0);  chk({w, "_rgb_b"}, 32'(rgb_b), 0);
      chk({w, "_hs_b"}, 32'(hs_b),  0);  chk({w, "_vs_b"}, 32'(vs_b),  0);
      chk({w, "_x_c"},  32'(x_c),   0);  chk({w, "_y_c"},  32'(y_c),   0);
      chk({w, "_ls_c"}, 32'(ls_c),  1);  chk({w, "_fs_c"}, 32'(fs_c),  1);
      chk({w, "_va_c"}, 32'(va_c),  0);  chk({w, "_rgb_c"}, 32'(rgb_c), 0);
      chk({w, "_hs_c"}, 32'(hs_c),  1);  chk({w, "_vs_c"}, 32'(vs_c),  1);
   endtask

   initial begin
      int n_a, f_a, l_a, n_b, f_b, l_b, ls1, ls2, n, rgb_hold;
      int n_vs, f_vs, l_vs, n_va, l_va, fs1, fs2;
      int pk[8];
      int pv[8];
      pk = '{1, 80, 81, 160, 161, 561, 640, 641};
      pv = '{8'h00, 8'h00, 8'h49, 8'h49, 8'h92, 8'hFF, 8'hFF, 8'h00};

      reset = 1'b1; enable = 1'b1; pattern_en = 1'b0;
      repeat (3) tick();
      chk_reset("por");
      reset = 1'b0;

      // Two default lines: sync windows, line period, latency-3 colour path
      n_a = 0; f_a = -1; l_a = -1; n_b = 0; f_b = -1; l_b = -1; ls1 = -1; ls2 = -1;
      for (int k = 1; k <= 1600; k++) begin
         tick();
         if (k <= 800 && hs_a == 1'b0) begin
            n_a++; if (f_a < 0) f_a = int'(x_a); l_a = int'(x_a);
         end
         if (k <= 800 && hs_b == 1'b1) begin
            n_b++; if (f_b < 0) f_b = int'(x_b); l_b = int'(x_b);
         end
         if (ls_a) begin
            if (ls1 < 0) ls1 = k; else if (ls2 < 0) ls2 = k;
         end
         if (k == 300) chk("x_at_300", 32'(x_a), 300);
         if (k == 800) chk("y_after_line", 32'(y_a), 1);
         if (k == 100) chk("lat3_rgb_x100", 32'(rgb_b), 97);
         if (k == 300) chk("lat3_rgb_x300", 32'(rgb_b), 41);
         if (k == 642) begin
            chk("lat3_rgb_x642", 32'(rgb_b), 127);
            chk("lat3_va_x642", 32'(va_b), 1);
         end
         if (k == 643) begin
            chk("lat3_rgb_x643", 32'(rgb_b), 0);
            chk("lat3_va_x643", 32'(va_b), 0);
         end
      end
      chk("hs_low_count", 32'(n_a), 96);
      chk("hs_low_first", 32'(f_a), 657);
      chk("hs_low_last", 32'(l_a), 752);
      chk("hs_pol1_count", 32'(n_b), 96);
      chk("hs_pol1_first", 32'(f_b), 659);
      chk("hs_pol1_last", 32'(l_b), 754);
      chk("line_start_1", 32'(ls1), 800);
      chk("line_start_2", 32'(ls2), 1600);

      // Colour-bar pattern on line 2
      pattern_en = 1'b1;
      for (int k = 1; k <= 800; k++) begin
         tick();
         for (int j = 0; j < 8; j++)
            if (k == pk[j]) chk($sformatf("pattern_x%0d", k), 32'(rgb_a), 32'(pv[j]));
      end
      pattern_en = 1'b0;

      // Asynchronous reset mid-line, then an enable gap
      repeat (300) tick();
      chk("pre_reset_x", 32'(x_a), 300);
      chk("pre_reset_y", 32'(y_a), 3);
      reset = 1'b1;
      #1;
      chk_reset("async");
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("restart_x", 32'(x_a), 1);
      chk("restart_y", 32'(y_a), 0);
      repeat (299) tick();
      enable = 1'b0;
      rgb_hold = 43;
      repeat (10) tick();
      chk("gap_x_frozen", 32'(x_a), 300);
      chk("gap_rgb_frozen", 32'(rgb_a), 32'(rgb_hold));
      enable = 1'b1;
      n = 0;
      while (!ls_a && n < 2000) begin
         tick();
         n++;
      end
      chk("stretched_line_len", 32'(310 + n), 810);

      // Whole frames of the miniature geometry (24 x 10)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vs = 0; f_vs = -1; l_vs = -1; n_va = 0; l_va = -1; fs1 = -1; fs2 = -1;
      for (int k = 1; k <= 480; k++) begin
         tick();
         if (k <= 240) begin
            if (vs_c == 1'b0) begin
               n_vs++; if (f_vs < 0) f_vs = k; l_vs = k;
            end
            if (va_c) begin
               n_va++; l_va = k;
            end
         end
         if (fs_c) begin
            if (fs1 < 0) fs1 = k; else if (fs2 < 0) fs2 = k;
         end
      end
      chk("vs_low_count", 32'(n_vs), 48);
      chk("vs_low_first", 32'(f_vs), 169);
      chk("vs_low_last", 32'(l_vs), 216);
      chk("va_count", 32'(n_va), 96);
      chk("va_last", 32'(l_va), 136);
      chk("frame_start_1", 32'(fs1), 240);
      chk("frame_start_2", 32'(fs2), 480);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen_p.md
Name: vga_timing_gen_p

Overview:
- Parametrised VGA timing generator and pixel output stage. It is the next generation of the fixed 640x480 VGA_Top used in the tt_um top-level.
- Generates h/v counters, sync pulses of configurable polarity, pixel coordinates and frame/line strobes for the graphics controller.
- Returns the controller's combinational colour through a configurable-latency pipeline, with syncs and blanking delay-matched.
- Adds a built-in colour-bar test-pattern mode and a clock enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, h_sync active level (0 = active-low)
- VS_POL, 0, v_sync active level
- COLOR_W, 8, colour bus width
- LATENCY, 1, output pipeline depth, legal range 1..4

Ports:
- pixel_clk  in  1  pixel clock; all registers on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  clock enable; low freezes every register
- pattern_en  in  1  1 = colour-bar test pattern replaces color_data
- color_data  in  COLOR_W  pixel colour for current x/y, combinational from graphics controller
- x  out  H_W  current horizontal count, H_W = $clog2(H_TOTAL)
- y  out  V_W  current vertical count, V_W = $clog2(V_TOTAL)
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 && y==0
- video_active  out  1  delayed active-area flag, aligned to rgb_out
- rgb_out  out  COLOR_W  pixel colour, zero in blanking
- h_sync  out  1  delayed horizontal sync
- v_sync  out  1  delayed vertical sync

Behaviour:
- Frame geometry: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on the h_cnt wrap and wraps to 0 after V_TOTAL-1.
  - Both advance only when enable=1.
- Request side: x/y/line_start/frame_start come directly from the counter registers. They carry no pipeline delay.
- Active area: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Sync decode:
  - hs_raw asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - Output level is the POL value when asserted and its inverse otherwise.
- Colour select:
  - pattern_en=0: pix = color_data.
  - pattern_en=1: bar index b = floor(h_cnt*8/H_ACTIVE) for 0..7, implemented as a constant-compare chain with no divider; pix bit i = b[i mod 3].
  - pix is forced to 0 when !active.
- Pipeline:
  - {pix, active, hs, vs} pass through LATENCY register stages.
  - Outputs change exactly LATENCY enabled cycles after the counter state that produced them.
  - pattern_en and color_data are sampled in the same cycle as the corresponding x/y.
- Enable low: counters and all pipeline stages hold; outputs are stable.
- Reset, asynchronous and any time, including mid-line or mid-frame:
  - h_cnt = v_cnt = 0.
  - All pipeline stages = {0, 0, ~HS_POL, ~VS_POL}.
  - Hence rgb_out=0, video_active=0, h_sync=~HS_POL, v_sync=~VS_POL, x=y=0, line_start=frame_start=1.
  - After reset release, counting resumes from 0,0 on the first enabled edge.
- Width: counter widths come from $clog2 of the totals. No overflow is possible because the compare-to-total wrap precedes the counter limit.

Test Plan:
1. Defaults, enable=1, reset released at cycle 0 -> h_sync low for exactly 96 cycles, spanning cycles 657..752 of line 0; line period 800 cycles; line_start high at x=0 every 800 cycles.
2. Run one full frame -> frame_start period 420000 cycles; v_sync low during lines 490 and 491 only; video_active high for 640 cycles per line on lines 0..479, count 307200 per frame.
3. color_data = x[7:0], LATENCY=3 -> rgb_out equals the x value from 3 cycles earlier; rgb_out=0 whenever video_active=0, e.g. at x=640+3 in output time.
4. pattern_en=1, COLOR_W=8 -> x=0..79 gives rgb 0x00, x=80..159 gives b=1 = 0x49, x=560..639 gives b=7 = 0xFF.
5. HS_POL=1, VS_POL=1 -> syncs idle low and pulse high with the same timing as tests 1–2; reset value 0.
6. Assert reset at x=300, y=200, then deassert; toggle enable low for 10 cycles mid-line -> immediate outputs at reset values; restart from 0,0; x frozen during the enable gap and line length extended by exactly 10 cycles.
